// File: rtl/rtc.sv
// Real-time clock: a 62-bit ns accumulator (30 ns + 32 fraction) plus a 48-bit seconds counter.
// Latency: loads and increments appear on the outputs one clk after the cycle that causes them.
// Backpressure: none. Load strobes are single-cycle and always accepted; rst overrides every load.
//
// Ports:
//   clk, rst                              clock and synchronous active-high reset
//   time_ld_in, time_reg_ns_in/_sec_in    absolute time load
//   period_ld_in, period_in,
//   time_acc_modulo_in                    nominal increment and ns wrap point
//   adj_ld_in, adj_ld_data_in,
//   period_adj_in                         temporary increment for N cycles
//   time_reg_ns_out, time_reg_sec_out     current time
//   one_pps_out                           one-cycle pulse on each ns wrap
//   adj_busy_out                          adjustment window active
module rtc #(
    parameter logic [39:0] RST_PERIOD = 40'h08_0000_0000,
    parameter logic [37:0] RST_MODULO = 38'h3B_9ACA_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        time_ld_in,
    input  logic [37:0] time_reg_ns_in,
    input  logic [47:0] time_reg_sec_in,
    input  logic        period_ld_in,
    input  logic [39:0] period_in,
    input  logic [37:0] time_acc_modulo_in,
    input  logic        adj_ld_in,
    input  logic [31:0] adj_ld_data_in,
    input  logic [39:0] period_adj_in,
    output logic [37:0] time_reg_ns_out,
    output logic [47:0] time_reg_sec_out,
    output logic        one_pps_out,
    output logic        adj_busy_out
);

    logic [61:0] acc;
    logic [47:0] sec;
    logic        pps;
    logic [39:0] period_r;
    logic [37:0] modulo_r;
    logic [39:0] period_adj_r;
    logic [31:0] adj_cnt;
    logic        adj_busy_r;

    logic [39:0] inc;
    logic [62:0] sum;
    logic [62:0] modulo_ext;
    logic [62:0] diff;
    logic        wrap;
    logic [31:0] adj_cnt_nxt;

    always_comb begin
        inc        = (adj_cnt != 32'd0) ? period_adj_r : period_r;
        // One extra bit so a huge modulo cannot make the sum overflow silently.
        sum        = {1'b0, acc} + {23'd0, inc};
        modulo_ext = {1'b0, modulo_r, 24'd0};
        diff       = sum - modulo_ext;
        // A single subtraction even if acc was already past a freshly lowered modulo.
        wrap       = (sum >= modulo_ext);

        adj_cnt_nxt = adj_cnt;
        if (adj_ld_in) begin
            adj_cnt_nxt = adj_ld_data_in;
        end else if (adj_cnt != 32'd0) begin
            adj_cnt_nxt = adj_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            sec          <= '0;
            pps          <= 1'b0;
            period_r     <= RST_PERIOD;
            modulo_r     <= RST_MODULO;
            period_adj_r <= '0;
            adj_cnt      <= '0;
            adj_busy_r   <= 1'b0;
        end else begin
            if (time_ld_in) begin
                acc <= {time_reg_ns_in, 24'd0};
                sec <= time_reg_sec_in;
                pps <= 1'b0;
            end else if (wrap) begin
                acc <= diff[61:0];
                sec <= sec + 48'd1;
                pps <= 1'b1;
            end else begin
                acc <= sum[61:0];
                pps <= 1'b0;
            end

            // New period/modulo take effect from the cycle after the load.
            if (period_ld_in) begin
                period_r <= period_in;
                modulo_r <= time_acc_modulo_in;
            end

            if (adj_ld_in) begin
                period_adj_r <= period_adj_in;
            end

            // The window keeps counting down through time loads.
            adj_cnt    <= adj_cnt_nxt;
            adj_busy_r <= (adj_cnt_nxt != 32'd0);
        end
    end

    assign time_reg_ns_out  = acc[61:24];
    assign time_reg_sec_out = sec;
    assign one_pps_out      = pps;
    assign adj_busy_out     = adj_busy_r;

endmodule

// File: tb/tb_rtc.sv
module tb_rtc;

    logic        clk;
    logic        rst;
    logic        time_ld_in;
    logic [37:0] time_reg_ns_in;
    logic [47:0] time_reg_sec_in;
    logic        period_ld_in;
    logic [39:0] period_in;
    logic [37:0] time_acc_modulo_in;
    logic        adj_ld_in;
    logic [31:0] adj_ld_data_in;
    logic [39:0] period_adj_in;
    logic [37:0] time_reg_ns_out;
    logic [47:0] time_reg_sec_out;
    logic        one_pps_out;
    logic        adj_busy_out;

    int tests_run;
    int tests_failed;

    localparam logic [39:0] P8      = 40'h08_0000_0000;
    localparam logic [37:0] MOD_1E9 = 38'h3B_9ACA_0000;
    localparam logic [37:0] NS_NEAR = 38'd999_999_992 << 8;

    rtc dut (
        .clk                (clk),
        .rst                (rst),
        .time_ld_in         (time_ld_in),
        .time_reg_ns_in     (time_reg_ns_in),
        .time_reg_sec_in    (time_reg_sec_in),
        .period_ld_in       (period_ld_in),
        .period_in          (period_in),
        .time_acc_modulo_in (time_acc_modulo_in),
        .adj_ld_in          (adj_ld_in),
        .adj_ld_data_in     (adj_ld_data_in),
        .period_adj_in      (period_adj_in),
        .time_reg_ns_out    (time_reg_ns_out),
        .time_reg_sec_out   (time_reg_sec_out),
        .one_pps_out        (one_pps_out),
        .adj_busy_out       (adj_busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        time_ld_in   = 1'b0;
        period_ld_in = 1'b0;
        adj_ld_in    = 1'b0;
    endtask

    task automatic load_time(input logic [37:0] ns, input logic [47:0] s);
        time_ld_in      = 1'b1;
        time_reg_ns_in  = ns;
        time_reg_sec_in = s;
        tick();
        time_ld_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_strobes();
        time_reg_ns_in     = '0;
        time_reg_sec_in    = '0;
        period_in          = '0;
        time_acc_modulo_in = '0;
        adj_ld_data_in     = '0;
        period_adj_in      = '0;
        tick();
        tick();
        tests_run++;
        if (time_reg_ns_out !== 38'd0 || time_reg_sec_out !== 48'd0 ||
            one_pps_out !== 1'b0 || adj_busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: ns=%h sec=%h pps=%b busy=%b, want all 0",
                     time_reg_ns_out, time_reg_sec_out, one_pps_out, adj_busy_out);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (time_reg_ns_out !== 38'h800) begin
            tests_failed++;
            $display("FAIL first_inc: ns=%h want 800", time_reg_ns_out);
        end
        for (int i = 0; i < 9; i++) tick();
        tests_run++;
        if (time_reg_ns_out !== 38'h5000 || time_reg_sec_out !== 48'd0 || one_pps_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL ten_inc: ns=%h sec=%h pps=%b want 5000/0/0",
                     time_reg_ns_out, time_reg_sec_out, one_pps_out);
        end
    endtask

    task automatic test_period();
        // Time load and period load in the same cycle: acc goes to 0, new period from next cycle.
        time_ld_in         = 1'b1;
        time_reg_ns_in     = '0;
        time_reg_sec_in    = '0;
        period_ld_in       = 1'b1;
        period_in          = 40'h08_8000_0000;
        time_acc_modulo_in = MOD_1E9;
        tick();
        clear_strobes();
        tests_run++;
        if (time_reg_ns_out !== 38'd0) begin
            tests_failed++;
            $display("FAIL period_load_time: ns=%h want 0", time_reg_ns_out);
        end
        tick();
        tick();
        tests_run++;
        if (time_reg_ns_out !== 38'h1100) begin
            tests_failed++;
            $display("FAIL period_8p5: ns=%h want 1100", time_reg_ns_out);
        end
        // Restoring 8 ns: the load cycle still adds 8.5 ns.
        period_ld_in = 1'b1;
        period_in    = P8;
        tick();
        period_ld_in = 1'b0;
        tests_run++;
        if (time_reg_ns_out !== 38'h1980) begin
            tests_failed++;
            $display("FAIL period_old_on_load: ns=%h want 1980", time_reg_ns_out);
        end
        tick();
        tests_run++;
        if (time_reg_ns_out !== 38'h2180) begin
            tests_failed++;
            $display("FAIL period_new_after_load: ns=%h want 2180", time_reg_ns_out);
        end
    endtask

    task automatic test_wrap();
        load_time(NS_NEAR, 48'd5);
        tests_run++;
        if (time_reg_ns_out !== NS_NEAR || time_reg_sec_out !== 48'd5 || one_pps_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_load: ns=%h sec=%h pps=%b want %h/5/0",
                     time_reg_ns_out, time_reg_sec_out, one_pps_out, NS_NEAR);
        end
        tick();
        tests_run++;
        if (time_reg_ns_out !== 38'd0 || time_reg_sec_out !== 48'd6 || one_pps_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_edge: ns=%h sec=%h pps=%b want 0/6/1",
                     time_reg_ns_out, time_reg_sec_out, one_pps_out);
        end
        tick();
        tests_run++;
        if (time_reg_ns_out !== 38'h800 || time_reg_sec_out !== 48'd6 || one_pps_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_after: ns=%h sec=%h pps=%b want 800/6/0",
                     time_reg_ns_out, time_reg_sec_out, one_pps_out);
        end
    endtask

    task automatic test_sec_wrap();
        load_time(NS_NEAR, 48'hFFFF_FFFF_FFFF);
        tick();
        tests_run++;
        if (time_reg_ns_out !== 38'd0 || time_reg_sec_out !== 48'd0 || one_pps_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL sec_wrap: ns=%h sec=%h pps=%b want 0/0/1",
                     time_reg_ns_out, time_reg_sec_out, one_pps_out);
        end
    endtask

    task automatic test_modulo_change();
        // acc lands above a freshly lowered modulo: exactly one subtraction.
        time_ld_in         = 1'b1;
        time_reg_ns_in     = 38'd500 << 8;
        time_reg_sec_in    = '0;
        period_ld_in       = 1'b1;
        period_in          = P8;
        time_acc_modulo_in = 38'd100 << 8;
        tick();
        clear_strobes();
        tick();
        tests_run++;
        if (time_reg_ns_out !== (38'd408 << 8) || time_reg_sec_out !== 48'd1 || one_pps_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL modulo_single_sub: ns=%h sec=%h pps=%b want %h/1/1",
                     time_reg_ns_out, time_reg_sec_out, one_pps_out, 38'd408 << 8);
        end
        // Restore 1e9; the load cycle still wraps at the old 100 ns.
        period_ld_in       = 1'b1;
        time_acc_modulo_in = MOD_1E9;
        tick();
        period_ld_in = 1'b0;
        tests_run++;
        if (time_reg_ns_out !== (38'd316 << 8) || time_reg_sec_out !== 48'd2) begin
            tests_failed++;
            $display("FAIL modulo_old_on_load: ns=%h sec=%h want %h/2",
                     time_reg_ns_out, time_reg_sec_out, 38'd316 << 8);
        end
        tick();
        tests_run++;
        if (time_reg_ns_out !== (38'd324 << 8) || one_pps_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL modulo_new: ns=%h pps=%b want %h/0",
                     time_reg_ns_out, one_pps_out, 38'd324 << 8);
        end
    endtask

    task automatic test_adj();
        logic [37:0] exp_ns [5];
        logic        exp_busy [5];
        exp_ns   = '{38'h800, 38'h1100, 38'h1A00, 38'h2300, 38'h2B00};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        load_time('0, '0);
        adj_ld_in      = 1'b1;
        adj_ld_data_in = 32'd3;
        period_adj_in  = 40'h09_0000_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            adj_ld_in = 1'b0;
            tests_run++;
            if (time_reg_ns_out !== exp_ns[i] || adj_busy_out !== exp_busy[i]) begin
                tests_failed++;
                $display("FAIL adj_window[%0d]: ns=%h busy=%b want %h/%b",
                         i, time_reg_ns_out, adj_busy_out, exp_ns[i], exp_busy[i]);
            end
        end
    endtask

    task automatic test_adj_zero();
        load_time('0, '0);
        adj_ld_in      = 1'b1;
        adj_ld_data_in = 32'd0;
        period_adj_in  = 40'h09_0000_0000;
        tick();
        adj_ld_in = 1'b0;
        tick();
        tests_run++;
        if (time_reg_ns_out !== 38'h1000 || adj_busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL adj_zero: ns=%h busy=%b want 1000/0", time_reg_ns_out, adj_busy_out);
        end
    endtask

    task automatic test_adj_through_time_ld();
        adj_ld_in      = 1'b1;
        adj_ld_data_in = 32'd2;
        period_adj_in  = 40'h09_0000_0000;
        tick();
        adj_ld_in = 1'b0;
        load_time('0, '0);
        tests_run++;
        if (time_reg_ns_out !== 38'd0 || adj_busy_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL adj_during_ld: ns=%h busy=%b want 0/1", time_reg_ns_out, adj_busy_out);
        end
        tick();
        tests_run++;
        if (time_reg_ns_out !== 38'h900 || adj_busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL adj_after_ld: ns=%h busy=%b want 900/0", time_reg_ns_out, adj_busy_out);
        end
    endtask

    task automatic test_rst_abort();
        adj_ld_in      = 1'b1;
        adj_ld_data_in = 32'd100;
        period_adj_in  = 40'h09_0000_0000;
        tick();
        adj_ld_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (adj_busy_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_abort_pre: busy=%b want 1", adj_busy_out);
        end
        // Reset wins over a simultaneous time load.
        rst             = 1'b1;
        time_ld_in      = 1'b1;
        time_reg_ns_in  = 38'd500 << 8;
        time_reg_sec_in = 48'd7;
        tick();
        rst        = 1'b0;
        time_ld_in = 1'b0;
        tests_run++;
        if (time_reg_ns_out !== 38'd0 || time_reg_sec_out !== 48'd0 ||
            one_pps_out !== 1'b0 || adj_busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_abort: ns=%h sec=%h pps=%b busy=%b want all 0",
                     time_reg_ns_out, time_reg_sec_out, one_pps_out, adj_busy_out);
        end
        tick();
        tests_run++;
        if (time_reg_ns_out !== 38'h800 || adj_busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_abort_after: ns=%h busy=%b want 800/0", time_reg_ns_out, adj_busy_out);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_period();
        test_wrap();
        test_sec_wrap();
        test_modulo_change();
        test_adj();
        test_adj_zero();
        test_adj_through_time_ld();
        test_rst_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rtc.md
RTC -- requirements
Module: rtc

Interface
REQ-001 Parameter RST_PERIOD, default 40'h08_0000_0000, meaning period loaded at reset (8 ns; 8-bit ns + 32-bit fraction).
REQ-002 Parameter RST_MODULO, default 38'h3B_9ACA_0000, meaning ns wrap modulo loaded at reset (1e9 ns; 30-bit ns + 8-bit fraction).
REQ-003 clk  in  1  clock; the only clock of the block.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 time_ld_in  in  1  load time from time_reg_ns_in/time_reg_sec_in this cycle.
REQ-006 time_reg_ns_in  in  38  ns load value; 30-bit ns + 8-bit fraction.
REQ-007 time_reg_sec_in  in  48  seconds load value.
REQ-008 period_ld_in  in  1  load period_in and time_acc_modulo_in this cycle.
REQ-009 period_in  in  40  nominal increment per clk; 8-bit ns + 32-bit fraction.
REQ-010 time_acc_modulo_in  in  38  ns wrap point; 30-bit ns + 8-bit fraction.
REQ-011 adj_ld_in  in  1  start an adjustment window this cycle.
REQ-012 adj_ld_data_in  in  32  adjustment window length in clk cycles.
REQ-013 period_adj_in  in  40  increment used during the adjustment window; same format as period_in.
REQ-014 time_reg_ns_out  out  38  current ns time; 30-bit ns + 8-bit fraction.
REQ-015 time_reg_sec_out  out  48  current seconds.
REQ-016 one_pps_out  out  1  one-cycle pulse on each ns wrap.
REQ-017 adj_busy_out  out  1  high while adjustment window active.

Function
REQ-018 The block SHALL hold a 62-bit ns accumulator (30 ns + 32 fraction); time_reg_ns_out SHALL equal accumulator[61:24], registered, no extra latency.
REQ-019 Registers period_r (40) and modulo_r (38) SHALL load on period_ld_in; the load cycle's increment SHALL use the old values; new values apply from the next cycle.
REQ-020 Increment selection: inc = period_adj_r when adj counter != 0, else period_r; each increment is zero-extended to 62 bits.
REQ-021 Every cycle without time_ld_in: sum = acc + inc; modulo_ext = {modulo_r, 24'd0}; if sum >= modulo_ext then acc <= sum - modulo_ext, sec <= sec + 1, one_pps_out <= 1; else acc <= sum, one_pps_out <= 0.
REQ-022 At most one wrap per cycle; subtraction SHALL be applied once only, including when acc already >= modulo_ext after a modulo change.
REQ-023 Seconds SHALL wrap from 48'hFFFF_FFFF_FFFF to 0 without flags.
REQ-024 time_ld_in SHALL set acc <= {time_reg_ns_in, 24'd0}, sec <= time_reg_sec_in, one_pps_out <= 0, with no increment that cycle; it has priority over increment only.
REQ-025 adj_ld_in SHALL load adj counter <= adj_ld_data_in and period_adj_r <= period_adj_in; the load cycle's increment uses the pre-load selection; a reload while active restarts the window.
REQ-026 Adj counter SHALL decrement by 1 on each cycle it is nonzero and adj_ld_in is low; adj_ld_data_in = 0 SHALL produce no window.
REQ-027 adj_busy_out SHALL equal (adj counter != 0), registered; window of N gives exactly N cycles of period_adj_r increments and N cycles of adj_busy_out high.
REQ-028 Simultaneous time_ld_in, period_ld_in, adj_ld_in SHALL all take effect in the same cycle, each per its own rule.
REQ-029 Counter decrement SHALL continue during time_ld_in cycles.

Reset
REQ-030 On rst: acc = 0, sec = 0, period_r = RST_PERIOD, modulo_r = RST_MODULO, period_adj_r = 0, adj counter = 0; all outputs 0 in the cycle after rst.
REQ-031 rst SHALL override all load inputs and abort any adjustment window.

Verification
REQ-032 Release rst, defaults -> time_reg_ns_out = 0x800 after 1 cycle, 0x5000 after 10 cycles; sec 0; one_pps_out 0.
REQ-033 period_ld period_in 40'h08_8000_0000 at ns 0 -> 2 cycles after new value applies, ns advanced by 0x1100 (17 ns).
REQ-034 time_ld ns = 999_999_992<<8, sec 5 -> next cycle ns 0, sec 6, one_pps_out high exactly 1 cycle.
REQ-035 time_ld sec 48'hFFFF_FFFF_FFFF, ns 999_999_992<<8 -> next cycle sec 0, ns 0, one_pps_out 1.
REQ-036 adj_ld data 3, period_adj 40'h09_0000_0000 -> 3 increments of 0x900 then 0x800; adj_busy_out high 3 cycles.
REQ-037 adj_ld data 100, rst after 10 cycles -> adj_busy_out 0, increments revert to RST_PERIOD, outputs 0.
